// File: rtl/mem_tx_arbiter.sv
// mem_tx_arbiter
//   Shares the single memory_interface TX channel between NREQ requesters
//   (0 = prefetcher, 1 = scheduler; a higher index has higher priority). It
//   also keeps an ordered FIFO of in-flight read commands so that each RX
//   reply can be steered back to the requester that issued it.
//
// Ports
//   clk, reset                  clock, asynchronous active-low reset
//   req_valid[NREQ]             requester i has a command ready
//   req_command                 packed commands, requester i at [i*CMD_BITS +: CMD_BITS]
//   req_data                    packed TX payload, requester i at [i*IO_BITS +: IO_BITS]
//   req_reply[NREQ]             the reply to a tracked command is wanted (0: discard it)
//   req_lock[NREQ]              claim or keep the channel between commands
//   mem_tx_command_valid/_command/_data   TX channel towards memory_interface
//   mem_tx_command_started      memory_interface accepted the presented command
//   mem_tx_active               memory_interface is busy with a transaction
//   mem_rx_done                 last cycle of a reply
//   tx_grant[NREQ]              one-hot TX owner
//   rx_owner[NREQ]              one-hot owner of the current reply, zero if empty/discarded
//   outstanding                 number of tracked commands awaiting a reply
//   full                        outstanding == DEPTH
//
// Handshake: the granted requester presents a command with
// mem_tx_command_valid; the transfer happens in the cycle memory_interface
// raises mem_tx_command_started. Replies carry no ready and are consumed on
// mem_rx_done, in issue order.
module mem_tx_arbiter #(
  parameter int NREQ     = 2,
  parameter int IO_BITS  = 2,
  parameter int CMD_BITS = 3,
  parameter logic [CMD_BITS-1:0] TRACK_CMD = CMD_BITS'(2),
  parameter int DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*CMD_BITS-1:0] req_command,
  input  logic [NREQ*IO_BITS-1:0]  req_data,
  input  logic [NREQ-1:0]          req_reply,
  input  logic [NREQ-1:0]          req_lock,
  output logic                     mem_tx_command_valid,
  output logic [CMD_BITS-1:0]      mem_tx_command,
  output logic [IO_BITS-1:0]       mem_tx_data,
  input  logic                     mem_tx_command_started,
  input  logic                     mem_tx_active,
  input  logic                     mem_rx_done,
  output logic [NREQ-1:0]          tx_grant,
  output logic [NREQ-1:0]          rx_owner,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                     full
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // ---------------------------------------------------------------- grant
  logic [NREQ-1:0] want;
  logic [GW-1:0]   held_grant;
  logic [GW-1:0]   winner;
  logic [GW-1:0]   g;

  assign want = req_valid | req_lock;

  always_comb begin
    winner = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (want[i]) winner = GW'(i);
    end
    // A locked owner keeps the channel even against higher priority.
    if (req_lock[held_grant]) winner = held_grant;
  end

  // The grant is frozen while memory_interface is mid-transaction.
  assign g        = mem_tx_active ? held_grant : winner;
  assign tx_grant = NREQ'(1) << g;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held_grant <= '0;
    end else if (!mem_tx_active) begin
      held_grant <= winner;
    end
  end

  // --------------------------------------------------------------- TX mux
  assign mem_tx_command = req_command[g*CMD_BITS +: CMD_BITS];
  assign mem_tx_data    = req_data[g*IO_BITS +: IO_BITS];
  // Only tracked reads need a FIFO slot; writes pass even when full.
  assign mem_tx_command_valid = req_valid[g] && !(full && mem_tx_command == TRACK_CMD);

  // ----------------------------------------------------------- reply FIFO
  logic          fifo_want [DEPTH];
  logic [GW-1:0] fifo_id   [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push_req, do_push, do_pop, empty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    // Explicit wrap so DEPTH need not be a power of two.
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign push_req = mem_tx_command_started && (mem_tx_command == TRACK_CMD);
  assign do_pop   = mem_rx_done && !empty;
  assign do_push  = push_req && (!full || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_want[i] <= 1'b0;
        fifo_id[i]   <= '0;
      end
    end else begin
      if (do_push) begin
        fifo_want[wr_ptr] <= req_reply[g];
        fifo_id[wr_ptr]   <= g;
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  assign outstanding = count;
  // Head stays visible through the rx_done cycle; the pop takes effect after.
  assign rx_owner = (!empty && fifo_want[rd_ptr]) ? (NREQ'(1) << fifo_id[rd_ptr]) : '0;

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset)
    !(push_req && full && !mem_rx_done));
  a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!reset)
    !(mem_rx_done && empty));

endmodule

// File: tb/tb_mem_tx_arbiter.sv
// Directed testbench for mem_tx_arbiter. Inputs are driven 1 time unit after
// the rising edge; outputs are sampled before the next rising edge.
module tb_mem_tx_arbiter;

  localparam int NREQ = 2;
  localparam int IO_BITS = 2;
  localparam int CMD_BITS = 3;
  localparam logic [CMD_BITS-1:0] RD = 3'd2;  // tracked read
  localparam logic [CMD_BITS-1:0] WR = 3'd1;  // untracked write
  localparam int DEPTH = 4;

  // ------------------------------------------------ clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]          req_valid = '0;
  logic [CMD_BITS-1:0]      cmd0 = '0, cmd1 = '0;
  logic [NREQ*CMD_BITS-1:0] req_command;
  logic [NREQ*IO_BITS-1:0]  req_data = 4'b10_01;
  logic [NREQ-1:0]          req_reply = '0;
  logic [NREQ-1:0]          req_lock = '0;
  logic                     mem_tx_command_valid;
  logic [CMD_BITS-1:0]      mem_tx_command;
  logic [IO_BITS-1:0]       mem_tx_data;
  logic                     mem_tx_command_started = 1'b0;
  logic                     mem_tx_active = 1'b0;
  logic                     mem_rx_done = 1'b0;
  logic [NREQ-1:0]          tx_grant;
  logic [NREQ-1:0]          rx_owner;
  logic [$clog2(DEPTH+1)-1:0] outstanding;
  logic                     full;

  assign req_command = {cmd1, cmd0};

  mem_tx_arbiter #(
    .NREQ(NREQ), .IO_BITS(IO_BITS), .CMD_BITS(CMD_BITS),
    .TRACK_CMD(RD), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_command(req_command),
    .req_data(req_data),
    .req_reply(req_reply),
    .req_lock(req_lock),
    .mem_tx_command_valid(mem_tx_command_valid),
    .mem_tx_command(mem_tx_command),
    .mem_tx_data(mem_tx_data),
    .mem_tx_command_started(mem_tx_command_started),
    .mem_tx_active(mem_tx_active),
    .mem_rx_done(mem_rx_done),
    .tx_grant(tx_grant),
    .rx_owner(rx_owner),
    .outstanding(outstanding),
    .full(full)
  );

  // ------------------------------------------------ scoreboard
  int n_total = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ------------------------------------------------ driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle started pulse from the currently granted requester.
  task automatic start_pulse();
    mem_tx_command_started = 1'b1;
    step();
    mem_tx_command_started = 1'b0;
  endtask

  task automatic rx_pulse();
    mem_rx_done = 1'b1;
    step();
    mem_rx_done = 1'b0;
  endtask

  // ------------------------------------------------ stimulus
  initial begin
    // Reset state
    repeat (2) step();
    check_eq("rst_grant", tx_grant, 2'b01);
    check_eq("rst_outstanding", outstanding, 0);
    check_eq("rst_full", full, 0);
    check_eq("rst_rx_owner", rx_owner, 2'b00);
    check_eq("rst_valid", mem_tx_command_valid, 0);
    reset = 1'b1;
    step();

    // 1. Four reads from req 0 fill the FIFO; fifth read blocked, write passes.
    req_valid = 2'b01; cmd0 = RD; req_reply = 2'b01;
    #1;
    check_eq("t1_valid", mem_tx_command_valid, 1);
    check_eq("t1_data", mem_tx_data, 2'b01);
    for (int i = 0; i < 4; i++) begin
      start_pulse();
      check_eq("t1_outstanding", outstanding, i + 1);
    end
    check_eq("t1_full", full, 1);
    check_eq("t1_read_blocked", mem_tx_command_valid, 0);
    cmd0 = WR;
    #1;
    check_eq("t1_write_passes", mem_tx_command_valid, 1);
    check_eq("t1_rx_owner", rx_owner, 2'b01);
    for (int i = 0; i < 4; i++) rx_pulse();
    check_eq("t1_drained", outstanding, 0);
    check_eq("t1_not_full", full, 0);

    // 2. Priority when idle, grant frozen while active.
    req_valid = 2'b11; cmd1 = WR;
    #1;
    check_eq("t2_prio", tx_grant, 2'b10);
    check_eq("t2_data", mem_tx_data, 2'b10);
    step();
    mem_tx_active = 1'b1; req_valid = 2'b01;
    #1;
    check_eq("t2_held_a", tx_grant, 2'b10);
    step();
    check_eq("t2_held_b", tx_grant, 2'b10);
    check_eq("t2_valid_gone", mem_tx_command_valid, 0);
    mem_tx_active = 1'b0;
    #1;
    check_eq("t2_release", tx_grant, 2'b01);
    step();

    // 3. Lock on req 0 beats pending req 1 across two transactions.
    req_lock = 2'b01; req_valid = 2'b11;
    #1;
    check_eq("t3_lock_idle0", tx_grant, 2'b01);
    step();
    mem_tx_active = 1'b1;
    #1;
    check_eq("t3_lock_act0", tx_grant, 2'b01);
    step();
    mem_tx_active = 1'b0;
    #1;
    check_eq("t3_lock_idle1", tx_grant, 2'b01);
    step();
    mem_tx_active = 1'b1;
    #1;
    check_eq("t3_lock_act1", tx_grant, 2'b01);
    step();
    mem_tx_active = 1'b0; req_lock = 2'b00;
    #1;
    check_eq("t3_unlock", tx_grant, 2'b10);
    step();
    req_valid = 2'b00;
    step();

    // 4. Reads req0 (wanted), req1 (discarded), req0 (wanted).
    cmd0 = RD; cmd1 = RD;
    exp_q.push_back(32'b01); exp_q.push_back(32'b00); exp_q.push_back(32'b01);
    req_valid = 2'b01; req_reply = 2'b01;
    start_pulse();
    req_valid = 2'b10; req_reply = 2'b00;
    #1;
    check_eq("t4_grant_req1", tx_grant, 2'b10);
    start_pulse();
    req_valid = 2'b01; req_reply = 2'b01;
    start_pulse();
    req_valid = 2'b00;
    check_eq("t4_outstanding", outstanding, 3);
    while (exp_q.size() > 0) begin
      check_eq("t4_rx_owner", rx_owner, exp_q.pop_front());
      rx_pulse();
    end
    check_eq("t4_empty", outstanding, 0);
    check_eq("t4_owner_empty", rx_owner, 2'b00);

    // 5. Simultaneous push and pop with two outstanding.
    req_valid = 2'b10; req_reply = 2'b10;   // A: req1 wanted
    start_pulse();
    req_valid = 2'b01; req_reply = 2'b01;   // B: req0 wanted
    start_pulse();
    check_eq("t5_two", outstanding, 2);
    check_eq("t5_head_a", rx_owner, 2'b10);
    req_valid = 2'b10; req_reply = 2'b00;   // C: req1 discarded, with pop of A
    mem_tx_command_started = 1'b1; mem_rx_done = 1'b1;
    step();
    mem_tx_command_started = 1'b0; mem_rx_done = 1'b0; req_valid = 2'b00;
    check_eq("t5_still_two", outstanding, 2);
    check_eq("t5_head_b", rx_owner, 2'b01);
    rx_pulse();
    check_eq("t5_head_c", rx_owner, 2'b00);
    check_eq("t5_one", outstanding, 1);
    rx_pulse();
    check_eq("t5_zero", outstanding, 0);

    // 6. Reset during an active transaction with three outstanding.
    req_valid = 2'b01; req_reply = 2'b01;
    repeat (3) start_pulse();
    req_valid = 2'b10;
    step();
    mem_tx_active = 1'b1;
    #1;
    check_eq("t6_pre_grant", tx_grant, 2'b10);
    check_eq("t6_pre_outstanding", outstanding, 3);
    step();
    reset = 1'b0;
    #1;
    check_eq("t6_rst_outstanding", outstanding, 0);
    check_eq("t6_rst_grant", tx_grant, 2'b01);
    check_eq("t6_rst_rx_owner", rx_owner, 2'b00);
    check_eq("t6_rst_full", full, 0);
    step();
    req_valid = 2'b00; mem_tx_active = 1'b0;
    reset = 1'b1;
    step();
    check_eq("t6_after", outstanding, 0);

    // ---------------------------------------------- report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, total=%0d", n_total);
    $fatal(1);
  end

endmodule
